counter_mod_n: RTL

- Parametrised successor to the fixed 0..99 counters.
- Generic modulo-N counter with:
  - configurable width and modulus
  - up or down direction
  - runtime wrap or saturate mode
  - prescaled enable
  - synchronous clear and parallel load
  - registered terminal-count pulse
- Used as the common timebase/event counter for timers, display scanners and clock-enable generators.

---
 rtl/counter_mod_n.sv | 116 +++++++++++
 1 files changed

// File: rtl/counter_mod_n.sv
// Generic modulo-N up/down counter with prescaled enable, wrap/saturate mode and terminal-count pulse.
// Optional wrap counter output o_wraps is built when COUNTER_MOD_WRAPS_EN is defined.
module counter_mod_n #(
  parameter int WIDTH    = 7,
  parameter int MODULO   = 100,
  parameter int PRESCALE = 1,
  parameter int WRAP_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_sat_mode,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc,
  output logic             o_sat
`ifdef COUNTER_MOD_WRAPS_EN
  ,
  output logic [WRAP_W-1:0] o_wraps
`endif
);

  localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
  localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);

  if (MODULO < 2 || $clog2(MODULO) > WIDTH || PRESCALE < 1 || WRAP_W < 1) begin : g_param_check
    $fatal(1, "counter_mod_n: illegal parameters (need 2 <= MODULO <= 2**WIDTH, PRESCALE >= 1, WRAP_W >= 1)");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             tick;

  always_comb begin
    cnt_d = cnt_q;
    pre_d = pre_q;
    tc_d  = 1'b0;
    tick  = i_en && (pre_q == PRE_MAX);
    if (i_en) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
    if (i_clear) begin
      cnt_d = '0;
      pre_d = '0;
    end else if (i_load) begin
      // Out-of-range load values clamp to the top of the range
      cnt_d = ({1'b0, i_load_val} < MOD_EXT) ? i_load_val : CNT_MAX;
    end else if (tick) begin
      if (i_up) begin
        if (cnt_q >= CNT_MAX) begin
          if (!i_sat_mode) begin
            cnt_d = '0;
            tc_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          if (!i_sat_mode) begin
            cnt_d = CNT_MAX;
            tc_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      pre_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      tc_q  <= tc_d;
    end
  end

`ifdef COUNTER_MOD_WRAPS_EN
  logic [WRAP_W-1:0] wraps_q, wraps_d;

  always_comb begin
    wraps_d = wraps_q;
    if (i_clear) begin
      wraps_d = '0;
    end else if (tc_d && (wraps_q != '1)) begin
      wraps_d = wraps_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wraps_q <= '0;
    end else begin
      wraps_q <= wraps_d;
    end
  end

  assign o_wraps = wraps_q;
`endif

  assign o_cnt = cnt_q;
  assign o_tc  = tc_q;
  assign o_sat = i_sat_mode && ((i_up && (cnt_q == CNT_MAX)) || (!i_up && (cnt_q == '0)));

endmodule
